contador_programa: RTL and testbench
====================================

Name: contador_programa

Overview:
- Program-counter and fetch stage that sits directly around the 14-bit PC adder.
- Drives the current PC to the adder's `a` input; the adder's `b` input is tied externally to the increment.
- Consumes the adder's sum as the next sequential PC.
- Issues fetch requests to instruction memory and hands fetched instructions to decode through a valid/ready handshake; accepts branch redirects from execute.

Parameters:
- AW, 14, address/PC width; must equal the adder width.
- DW, 16, instruction word width.
- RESET_ADDR, 14'h0000, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pc_actual  output  AW  current PC; to adder input `a`.
- pc_sig  input  AW  adder sum (pc_actual + increment); next sequential PC.
- salto_en  input  1  branch/jump redirect strobe, one cycle.
- salto_dir  input  AW  redirect target, valid with salto_en.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  AW  fetch address; equals pc_actual.
- mem_ack  input  1  memory returns mem_data this cycle.
- mem_data  input  DW  fetched instruction.
- inst_valid  output  1  inst_out/inst_pc valid for decode.
- inst_ready  input  1  decode accepts the instruction.
- inst_out  output  DW  held instruction.
- inst_pc  output  AW  address of inst_out.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - On rst: pc=RESET_ADDR, state=INICIO, mem_req=0, inst_valid=0, inst_out=0, inst_pc=0, salto_pend=0.
  - Outputs drop immediately on rst assertion, including mid-request.
  - Any in-flight fetch is abandoned; a late mem_ack is ignored while in INICIO.
- States: INICIO, PEDIR, ESPERA_DEC. All state bits and outputs are registered; mem_req = (state==PEDIR).
- INICIO:
  - Always goes to PEDIR next cycle.
  - If salto_en is high, pc <= salto_dir.
- PEDIR, mem_req=1, mem_addr=pc:
  - On mem_ack with no branch pending and salto_en=0: inst_out<=mem_data, inst_pc<=pc, pc<=pc_sig, go ESPERA_DEC.
  - On mem_ack with salto_pend=1 or salto_en=1: discard data, pc<=target, clear salto_pend, stay PEDIR. Target is salto_dir if salto_en is high, else the stored target.
  - On salto_en without mem_ack: set salto_pend, store salto_dir, keep mem_addr stable until ack. The memory protocol forbids changing the address mid-request.
- ESPERA_DEC, inst_valid=1:
  - On inst_ready with salto_en=0: go PEDIR; inst_valid=0 next cycle.
  - On salto_en (with or without inst_ready): flush the held instruction (inst_valid=0 next cycle), pc<=salto_dir, go PEDIR. The branch always wins.
- Latency:
  - Minimum 2 cycles from entering PEDIR to inst_valid (ack in the first PEDIR cycle).
  - Sustained throughput: one instruction per 2 cycles with zero-wait memory.
- Width and wrap:
  - pc_sig is taken as-is; 14'h3FFF+1 wraps to 14'h0000, and no overflow flag is produced.
  - pc_actual always equals the registered pc.

Optional Feature:
- Macro: CONTADOR_PROGRAMA_CNT_EN.
- Defined:
  - Adds output port inst_cnt, 16 bits, reset 0.
  - Increments on every cycle with inst_valid & inst_ready & ~salto_en.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package `cpu_pkg`:
  - AW/DW constants.
  - State encoding localparams (INICIO=2'd0, PEDIR=2'd1, ESPERA_DEC=2'd2).
  - RESET_ADDR default.
- One natural sub-module, `registro_inst`: the instruction/PC holding register with load and flush enables. The FSM and PC register stay in the top module.
- The adder stays external.

Test Plan:
- Reset release, pc_sig tied to pc_actual+1 via the adder, mem_ack every PEDIR cycle, inst_ready=1 -> inst_pc sequence 0,1,2,3, one inst_valid every 2 cycles.
- inst_ready held 0 for 5 cycles in ESPERA_DEC -> inst_out/inst_pc stable, mem_req=0 throughout, pc already advanced by 1.
- salto_en with salto_dir=14'h0100 during PEDIR, ack 3 cycles later -> mem_addr unchanged until ack, data discarded, next request at 14'h0100, next inst_pc=14'h0100.
- salto_en with target 14'h0040 in ESPERA_DEC, same cycle as inst_ready=1 -> no transfer counted, inst_valid=0 next cycle, mem_addr=14'h0040.
- PC at 14'h3FFF fetched -> next mem_addr=14'h0000.
- rst pulsed mid-PEDIR -> mem_req falls within the same cycle, pc=RESET_ADDR; with CONTADOR_PROGRAMA_CNT_EN defined, inst_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and helpers for the program-counter / fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

  // Address / PC width; has to match the width of the external PC adder.
  localparam int CPU_AW = 14;

  // Instruction word width.
  localparam int CPU_DW = 16;

  // PC value loaded on reset.
  localparam logic [CPU_AW-1:0] CPU_RESET_ADDR = 14'h0000;

  // Width of the optional delivered-instruction counter.
  localparam int CNT_W = 16;

  // Fetch FSM states; the encoding is fixed so it can be probed from outside.
  typedef enum logic [1:0] {
    INICIO     = 2'd0,
    PEDIR      = 2'd1,
    ESPERA_DEC = 2'd2
  } estado_t;

  // Saturating increment for the delivered-instruction counter.
  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/contador_programa_registro_inst.sv
// Instruction/PC holding register between fetch and decode; load sets valid, flush clears it.
// Latency: 1 cycle from load to valid output.
// Backpressure: contents held unchanged while neither load nor flush is asserted.
module registro_inst
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int DW = CPU_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          carga,
  input  logic          vacia,
  input  logic [DW-1:0] dato,
  input  logic [AW-1:0] dir,
  output logic          valido,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc
);

  // Capture the fetched word and its address; a flush only drops the valid bit,
  // the stale word stays in place but is never presented as valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valido  <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else if (carga) begin
      valido  <= 1'b1;
      inst    <= dato;
      inst_pc <= dir;
    end else if (vacia) begin
      valido  <= 1'b0;
    end
  end

endmodule

// File: rtl/contador_programa.sv
// Program counter and fetch stage around the external PC adder; optional macro CONTADOR_PROGRAMA_CNT_EN adds inst_cnt.
// Latency: ack in the first PEDIR cycle gives inst_valid on the next cycle; one instruction per 2 cycles sustained.
// Backpressure: no new fetch is issued while decode holds inst_ready low; a branch always flushes the held instruction.
module contador_programa
  import cpu_pkg::*;
#(
  parameter int            AW         = CPU_AW,
  parameter int            DW         = CPU_DW,
  parameter logic [AW-1:0] RESET_ADDR = AW'(CPU_RESET_ADDR)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [AW-1:0]    pc_actual,
  input  logic [AW-1:0]    pc_sig,
  input  logic             salto_en,
  input  logic [AW-1:0]    salto_dir,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [DW-1:0]    inst_out,
  output logic [AW-1:0]    inst_pc
`ifdef CONTADOR_PROGRAMA_CNT_EN
  ,
  output logic [CNT_W-1:0] inst_cnt
`endif
);

  estado_t       estado;
  logic [AW-1:0] pc;
  logic [AW-1:0] salto_tgt;
  logic          salto_pend;
  logic          carga;
  logic          vacia;

  // The memory sees the registered PC directly; it only moves on ack or outside PEDIR,
  // which keeps the request address stable for the whole request.
  assign pc_actual = pc;
  assign mem_addr  = pc;

  // Accept the returned word only when no redirect is pending or arriving;
  // drop the held word when decode takes it or when a branch arrives.
  assign carga = (estado == PEDIR) && mem_ack && !salto_pend && !salto_en;
  assign vacia = (estado == ESPERA_DEC) && (salto_en || inst_ready);

  // Fetch FSM with the PC register, branch-pending latch and registered mem_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado     <= INICIO;
      pc         <= RESET_ADDR;
      salto_tgt  <= RESET_ADDR;
      salto_pend <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          // Any ack arriving here belongs to an abandoned request and is ignored.
          estado  <= PEDIR;
          mem_req <= 1'b1;
          if (salto_en) begin
            pc <= salto_dir;
          end
        end

        PEDIR: begin
          if (mem_ack) begin
            if (salto_pend || salto_en) begin
              // Returned word belongs to the wrong path: discard it and refetch at the target.
              pc         <= salto_en ? salto_dir : salto_tgt;
              salto_pend <= 1'b0;
            end else begin
              pc      <= pc_sig;
              estado  <= ESPERA_DEC;
              mem_req <= 1'b0;
            end
          end else if (salto_en) begin
            // The address may not change mid-request, so remember the target until the ack.
            salto_pend <= 1'b1;
            salto_tgt  <= salto_dir;
          end
        end

        ESPERA_DEC: begin
          if (salto_en) begin
            pc      <= salto_dir;
            estado  <= PEDIR;
            mem_req <= 1'b1;
          end else if (inst_ready) begin
            estado  <= PEDIR;
            mem_req <= 1'b1;
          end
        end

        default: begin
          estado     <= INICIO;
          mem_req    <= 1'b0;
          salto_pend <= 1'b0;
        end
      endcase
    end
  end

  registro_inst #(
    .AW(AW),
    .DW(DW)
  ) u_registro_inst (
    .clk    (clk),
    .rst    (rst),
    .carga  (carga),
    .vacia  (vacia),
    .dato   (mem_data),
    .dir    (pc),
    .valido (inst_valid),
    .inst   (inst_out),
    .inst_pc(inst_pc)
  );

`ifdef CONTADOR_PROGRAMA_CNT_EN
  // Count instructions actually handed to decode; a same-cycle branch cancels the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_cnt <= '0;
    end else if (inst_valid && inst_ready && !salto_en) begin
      inst_cnt <= inc_sat(inst_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_contador_programa.sv
// Self-checking bench for contador_programa: directed scenarios followed by random traffic.
// Reference: instruction-stream model (next delivered PC is previous+1 unless a branch intervened).
// Memory returns a fixed function of the address so every delivered word can be checked.
module tb_contador_programa;
  import cpu_pkg::*;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_actual;
  logic [AW-1:0] pc_sig;
  logic          salto_en;
  logic [AW-1:0] salto_dir;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
`ifdef CONTADOR_PROGRAMA_CNT_EN
  logic [CNT_W-1:0] inst_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [AW-1:0] exp_pc;
  int            n_deliv;
  logic          prev_wait;
  logic [AW-1:0] prev_addr;

  always #5 clk = ~clk;

  // The external 14-bit adder with the increment tied to 1.
  assign pc_sig = pc_actual + 14'd1;

  contador_programa dut (
    .clk       (clk),
    .rst       (rst),
    .pc_actual (pc_actual),
    .pc_sig    (pc_sig),
    .salto_en  (salto_en),
    .salto_dir (salto_dir),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out  (inst_out),
    .inst_pc   (inst_pc)
`ifdef CONTADOR_PROGRAMA_CNT_EN
    ,
    .inst_cnt  (inst_cnt)
`endif
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {2'b10, a} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock cycle: update the stream model from the pre-edge handshake,
  // cross the rising edge, then check at the falling edge.
  task automatic tick();
    mem_data = mem_word(mem_addr);
    if (inst_valid && inst_ready && !salto_en) begin
      chk("deliv_pc", inst_pc, exp_pc);
      chk("deliv_word", inst_out, mem_word(exp_pc));
      exp_pc = exp_pc + 14'd1;
      n_deliv++;
    end
    if (salto_en) exp_pc = salto_dir;
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr;
    @(posedge clk);
    @(negedge clk);
    if (prev_wait) begin
      chk("addr_hold", mem_addr, prev_addr);
      chk("req_hold", mem_req, 1);
    end
    if (inst_valid) chk("held_word", inst_out, mem_word(inst_pc));
`ifdef CONTADOR_PROGRAMA_CNT_EN
    chk("inst_cnt", inst_cnt, n_deliv);
`endif
  endtask

  task automatic model_reset();
    exp_pc    = 14'h0000;
    n_deliv   = 0;
    prev_wait = 1'b0;
    prev_addr = '0;
  endtask

  initial begin
    rst        = 1'b1;
    salto_en   = 1'b0;
    salto_dir  = '0;
    mem_ack    = 1'b0;
    mem_data   = '0;
    inst_ready = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", pc_actual, 14'h0000);
    chk("rst_inst", inst_out, 0);
    chk("rst_inst_pc", inst_pc, 0);
`ifdef CONTADOR_PROGRAMA_CNT_EN
    chk("rst_cnt", inst_cnt, 0);
`endif
    rst = 1'b0;

    // Streaming with zero-wait memory and an always-ready decoder.
    for (int i = 1; i <= 8; i++) begin
      mem_ack    = mem_req;
      inst_ready = 1'b1;
      tick();
      chk("stream_valid", inst_valid, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("stream_pc", inst_pc, i / 2 - 1);
    end

    // Decoder stall: held instruction stays put, no request, PC already advanced.
    inst_ready = 1'b0;
    mem_ack    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", inst_valid, 1);
      chk("stall_pc", inst_pc, 14'd3);
      chk("stall_word", inst_out, mem_word(14'd3));
      chk("stall_req", mem_req, 0);
      chk("stall_pc_act", pc_actual, 14'd4);
    end
    inst_ready = 1'b1;
    tick();
    chk("resume_req", mem_req, 1);
    chk("resume_addr", mem_addr, 14'd4);

    // Branch during a request; ack arrives three cycles later.
    salto_en  = 1'b1;
    salto_dir = 14'h0100;
    mem_ack   = 1'b0;
    tick();
    salto_en = 1'b0;
    chk("br_addr0", mem_addr, 14'd4);
    tick();
    chk("br_addr1", mem_addr, 14'd4);
    mem_ack = 1'b1;
    tick();
    chk("br_discard", inst_valid, 0);
    chk("br_req", mem_req, 1);
    chk("br_target", mem_addr, 14'h0100);
    tick();
    chk("br_valid", inst_valid, 1);
    chk("br_inst_pc", inst_pc, 14'h0100);
    mem_ack = 1'b0;

    // Branch in ESPERA_DEC together with inst_ready: flush, no transfer.
    salto_en   = 1'b1;
    salto_dir  = 14'h0040;
    inst_ready = 1'b1;
    tick();
    salto_en = 1'b0;
    chk("flush_valid", inst_valid, 0);
    chk("flush_req", mem_req, 1);
    chk("flush_addr", mem_addr, 14'h0040);
`ifdef CONTADOR_PROGRAMA_CNT_EN
    chk("flush_cnt", inst_cnt, 4);
`endif

    // Wrap: fetch at 14'h3FFF, next request at 14'h0000.
    salto_en  = 1'b1;
    salto_dir = 14'h3FFF;
    mem_ack   = 1'b1;
    tick();
    salto_en = 1'b0;
    chk("wrap_addr", mem_addr, 14'h3FFF);
    chk("wrap_nov", inst_valid, 0);
    tick();
    chk("wrap_inst_pc", inst_pc, 14'h3FFF);
    chk("wrap_pc", pc_actual, 14'h0000);
    mem_ack = 1'b0;
    tick();
    chk("wrap_req", mem_req, 1);
    chk("wrap_next", mem_addr, 14'h0000);

    // Advance to a nonzero PC, then reset in the middle of a request.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("pre_rst_addr", mem_addr, 14'd1);
    chk("pre_rst_req", mem_req, 1);
    #2;
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_pc", pc_actual, 14'h0000);
    chk("arst_valid", inst_valid, 0);
`ifdef CONTADOR_PROGRAMA_CNT_EN
    chk("arst_cnt", inst_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Late ack in INICIO is ignored.
    tick();
    chk("late_ack_valid", inst_valid, 0);
    chk("late_ack_req", mem_req, 1);
    chk("late_ack_addr", mem_addr, 14'h0000);

    // Random traffic against the stream model.
    for (int i = 0; i < 3000; i++) begin
      mem_ack    = mem_req && ($urandom_range(0, 9) < 6);
      inst_ready = ($urandom_range(0, 9) < 7);
      salto_en   = ($urandom_range(0, 15) == 0);
      salto_dir  = ($urandom_range(0, 3) == 0) ? (14'h3FFE + AW'($urandom_range(0, 1)))
                                               : AW'($urandom);
      tick();
    end
    salto_en = 1'b0;
    chk("rand_progress", (n_deliv > 200) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
